// File: rtl/shift_right_pipe_32b_if.sv
// Handshake bundle for the pipelined 32-bit right shifter.
// Master is the producer/consumer side; slave is the shifter itself.
interface shift_right_pipe_32b_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in;
    logic [4:0]  cntrl;
    logic        arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    modport master (
        output flush, in_valid, in, cntrl, arith, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  flush, in_valid, in, cntrl, arith, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/shift_right_pipe_32b.sv
// Three-register logarithmic right shifter (SRL/SRA) with valid/ready flow control.
// S1 shifts by 1/2, S2 by 4/8, S3 by 16; the fill bit travels with each operation.
module shift_right_pipe_32b (
    input  logic                   clk,
    input  logic                   rstn,
    shift_right_pipe_32b_if.slave  bus
);

    function automatic logic [31:0] shr_s1(input logic [31:0] d, input logic [1:0] c, input logic f);
        logic [31:0] t;
        t = c[0] ? {f, d[31:1]} : d;
        t = c[1] ? {{2{f}}, t[31:2]} : t;
        return t;
    endfunction

    function automatic logic [31:0] shr_s2(input logic [31:0] d, input logic [1:0] c, input logic f);
        logic [31:0] t;
        t = c[0] ? {{4{f}}, d[31:4]} : d;
        t = c[1] ? {{8{f}}, t[31:8]} : t;
        return t;
    endfunction

    function automatic logic [31:0] shr_s3(input logic [31:0] d, input logic c, input logic f);
        return c ? {{16{f}}, d[31:16]} : d;
    endfunction

    logic        r_vld_p1, r_vld_p2, r_vld_p3;
    logic [31:0] r_data_p1, r_data_p2, r_data_p3;
    logic [2:0]  r_cnt_p1;
    logic        r_cnt_p2;
    logic        r_fill_p1, r_fill_p2;

    logic        w_rdy_p3, w_rdy_p2, w_rdy_p1;
    logic        w_in_ready;
    logic        w_acc;
    logic        w_fill_in;

    // A stage can take new data if it is empty or its successor is moving.
    assign w_rdy_p3   = !r_vld_p3 | bus.out_ready;
    assign w_rdy_p2   = !r_vld_p2 | w_rdy_p3;
    assign w_rdy_p1   = !r_vld_p1 | w_rdy_p2;
    assign w_in_ready = w_rdy_p1 & !bus.flush;
    assign w_acc      = bus.in_valid & w_in_ready;
    assign w_fill_in  = bus.arith & bus.in[31];

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_vld_p3;
    assign bus.out       = r_data_p3;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_vld_p3  <= 1'b0;
            r_data_p1 <= '0;
            r_data_p2 <= '0;
            r_data_p3 <= '0;
            r_cnt_p1  <= '0;
            r_cnt_p2  <= 1'b0;
            r_fill_p1 <= 1'b0;
            r_fill_p2 <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_vld_p1 <= 1'b0;
                r_vld_p2 <= 1'b0;
                r_vld_p3 <= 1'b0;
            end else begin
                if (w_rdy_p1) r_vld_p1 <= w_acc;
                if (w_rdy_p2) r_vld_p2 <= r_vld_p1;
                if (w_rdy_p3) r_vld_p3 <= r_vld_p2;
            end

            // S1: shift by 1 and 2
            if (w_acc) begin
                r_data_p1 <= shr_s1(bus.in, bus.cntrl[1:0], w_fill_in);
                r_cnt_p1  <= bus.cntrl[4:2];
                r_fill_p1 <= w_fill_in;
            end

            // S2: shift by 4 and 8
            if (w_rdy_p2 && r_vld_p1) begin
                r_data_p2 <= shr_s2(r_data_p1, r_cnt_p1[1:0], r_fill_p1);
                r_cnt_p2  <= r_cnt_p1[2];
                r_fill_p2 <= r_fill_p1;
            end

            // S3: shift by 16, drives the output
            if (w_rdy_p3 && r_vld_p2) begin
                r_data_p3 <= shr_s3(r_data_p2, r_cnt_p2, r_fill_p2);
            end
        end
    end

endmodule

// File: tb/tb_shift_right_pipe_32b.sv
// Directed and streaming bench for shift_right_pipe_32b.
module tb_shift_right_pipe_32b;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    shift_right_pipe_32b_if bus ();

    shift_right_pipe_32b dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_shr(input logic [31:0] x, input logic [4:0] n, input logic a);
        logic signed [31:0] s;
        logic [31:0] r;
        if (a) begin
            s = $signed(x) >>> n;
            r = s;
        end else begin
            r = x >> n;
        end
        return r;
    endfunction

    task automatic test_reset();
        rstn          = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in        = '0;
        bus.cntrl     = '0;
        bus.arith     = 1'b0;
        #3;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++;
        if (bus.out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want 00000000", bus.out); end
        #9;
        rstn = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        step();
    endtask

    task automatic test_srl();
        bus.in = 32'h80000F00; bus.cntrl = 5'd4; bus.arith = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL srl_in_ready: got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL srl_lat1: out_valid %b want 0", bus.out_valid); end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL srl_lat2: out_valid %b want 0", bus.out_valid); end
        step();
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL srl_lat3: out_valid %b want 1", bus.out_valid); end
        checks++;
        if (bus.out !== 32'h080000F0) begin errors++; $display("FAIL srl_value: got %h want 080000f0", bus.out); end
        step();
    endtask

    task automatic test_sra();
        logic [31:0] vin [6]  = '{32'h80000F00, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h12345678, 32'h80000001};
        logic [4:0]  vc  [6]  = '{5'd4, 5'd31, 5'd31, 5'd31, 5'd0, 5'd0};
        logic        va  [6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] vexp[6]  = '{32'hF80000F0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h12345678, 32'h80000001};
        int n;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in = vin[i]; bus.cntrl = vc[i]; bus.arith = va[i]; bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            n = 0;
            while (!bus.out_valid && n < 6) begin step(); n++; end
            checks++;
            if (n !== 2) begin errors++; $display("FAIL sra_latency[%0d]: waited %0d want 2", i, n); end
            checks++;
            if (bus.out !== vexp[i]) begin errors++; $display("FAIL sra_value[%0d]: got %h want %h", i, bus.out, vexp[i]); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] exp_v;
        int  sent, got, occ;
        bit  acc, em, exp_rdy;
        sent = 0; got = 0; occ = 0;
        bus.in = $urandom; bus.cntrl = 5'($urandom_range(0, 31)); bus.arith = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 2000 && got < 64; cyc++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = (sent < 64);
            #1;
            exp_rdy = !(occ == 3 && !bus.out_ready);
            checks++;
            if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL stream_in_ready cyc %0d: got %b want %b", cyc, bus.in_ready, exp_rdy); end
            acc = bus.in_valid && bus.in_ready;
            em  = bus.out_valid && bus.out_ready;
            if (em) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stream_extra cyc %0d: got %h want nothing", cyc, bus.out);
                end else begin
                    exp_v = q.pop_front();
                    if (bus.out !== exp_v) begin errors++; $display("FAIL stream_value beat %0d: got %h want %h", got, bus.out, exp_v); end
                end
                got++;
            end
            if (acc) begin
                q.push_back(ref_shr(bus.in, bus.cntrl, bus.arith));
                sent++;
            end
            occ = occ + int'(acc) - int'(em);
            @(posedge clk);
            #1;
            if (acc) begin
                bus.in = $urandom; bus.cntrl = 5'($urandom_range(0, 31)); bus.arith = 1'($urandom_range(0, 1));
            end
        end
        checks++;
        if (got != 64 || q.size() != 0) begin errors++; $display("FAIL stream_count: got %0d beats, %0d pending, want 64 and 0", got, q.size()); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        step(); step(); step(); step();
    endtask

    task automatic test_stall();
        logic [31:0] ins [3] = '{32'hF0F0F0F0, 32'h80000000, 32'hDEADBEEF};
        logic [4:0]  cs  [3] = '{5'd1, 5'd8, 5'd16};
        logic        as  [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] exps[3] = '{32'h78787878, 32'hFF800000, 32'h0000DEAD};
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in = ins[k]; bus.cntrl = cs[k]; bus.arith = as[k]; bus.in_valid = 1'b1;
            step();
        end
        bus.in = 32'hAAAAAAAA; bus.cntrl = 5'd3; bus.arith = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %b want 0", c, bus.in_ready); end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== exps[0]) begin
                errors++; $display("FAIL stall_hold c%0d: got v=%b %h want v=1 %h", c, bus.out_valid, bus.out, exps[0]);
            end
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== exps[k]) begin
                errors++; $display("FAIL stall_drain[%0d]: got v=%b %h want v=1 %h", k, bus.out_valid, bus.out, exps[k]);
            end
            step();
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty: out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in = 32'h11111111 << k; bus.cntrl = 5'(k + 1); bus.arith = 1'b0; bus.in_valid = 1'b1;
            step();
        end
        bus.in = 32'h55555555; bus.cntrl = 5'd2; bus.flush = 1'b1; bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
        bus.in = 32'h80000F00; bus.cntrl = 5'd8; bus.arith = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_lat1: out_valid %b want 0", bus.out_valid); end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_lat2: out_valid %b want 0", bus.out_valid); end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 32'hFF80000F) begin
            errors++; $display("FAIL flush_result: got v=%b %h want v=1 ff80000f", bus.out_valid, bus.out);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_extra: out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in = 32'h12345678; bus.cntrl = 5'd4; bus.arith = 1'b0; bus.in_valid = 1'b1;
        step();
        bus.in = 32'h87654321; bus.cntrl = 5'd1; bus.arith = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 32'h01234567) begin
            errors++; $display("FAIL rstmid_pre: got v=%b %h want v=1 01234567", bus.out_valid, bus.out);
        end
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); end
        checks++;
        if (bus.out !== 32'h0) begin errors++; $display("FAIL rstmid_out: got %h want 00000000", bus.out); end
        #2;
        rstn = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
        step();
        bus.in = 32'hFFFF0000; bus.cntrl = 5'd12; bus.arith = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale: out_valid %b want 0", bus.out_valid); end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 32'hFFFFFFF0) begin
            errors++; $display("FAIL rstmid_result: got v=%b %h want v=1 fffffff0", bus.out_valid, bus.out);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_extra: out_valid %b want 0", bus.out_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_srl();
        test_sra();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
